// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared state encoding and constants for the FMUL run checker
package rv_pkg;

  typedef enum logic [2:0] {
    ST_RST,
    ST_RUN,
    ST_DRAIN,
    ST_CHECK,
    ST_DONE
  } rv_state_e;

  localparam logic [31:0] DMEM_BASE = 32'h0000_1000;
  localparam logic [31:0] FP32_SIX  = 32'h40C0_0000;

endpackage

// File: rtl/rv_chk_rom.sv
// rtl/rv_chk_rom.sv - expected-result table, word i held at EXP_VALS[32*i +: 32]
module rv_chk_rom
  import rv_pkg::*;
#(
  parameter int                 NCHK     = 4,
  parameter int                 IW       = (NCHK > 1) ? $clog2(NCHK) : 1,
  parameter logic [NCHK*32-1:0] EXP_VALS = {NCHK{FP32_SIX}}
) (
  input  logic [IW-1:0] idx_i,
  output logic [31:0]   data_o
);

  // Mux over real entries only, so a non-power-of-two NCHK never slices past the table.
  always_comb begin
    data_o = '0;
    for (int i = 0; i < NCHK; i++) begin
      if (int'(idx_i) == i) data_o = EXP_VALS[i*32 +: 32];
    end
  end

endmodule

// File: rtl/rv_run_checker.sv
// rtl/rv_run_checker.sv - core reset sequencer, halt watchdog and DMEM result checker
module rv_run_checker
  import rv_pkg::*;
#(
  parameter int                 RST_CYCLES = 5,
  parameter int                 TIMEOUT    = 10000,
  parameter int                 DRAIN      = 1,
  parameter int                 NCHK       = 4,
  parameter logic [31:0]        CHK_ADDR0  = DMEM_BASE + 32'h8,
  parameter logic [NCHK*32-1:0] EXP_VALS   = {NCHK{FP32_SIX}},
  parameter int                 CNT_W      = 32,
  localparam int                FW         = $clog2(NCHK + 1),
  localparam int                IW         = (NCHK > 1) ? $clog2(NCHK) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             halted,
  output logic             core_rstn,
  output logic             rd_en,
  output logic [31:0]      rd_addr,
  input  logic [31:0]      rd_data,
  output logic             done,
  output logic             pass,
  output logic             timed_out,
  output logic [FW-1:0]    fail_count,
  output logic [IW-1:0]    first_fail_idx,
  output logic [31:0]      first_fail_data,
  output logic [CNT_W-1:0] cycles
);

  rv_state_e        state_q;
  logic [31:0]      cnt_q;
  logic [IW-1:0]    idx_q;
  logic             core_rstn_q, rd_en_q, done_q, pass_q, timed_out_q;
  logic [31:0]      rd_addr_q, ff_data_q;
  logic [FW-1:0]    fail_count_q, fail_count_d;
  logic [IW-1:0]    ff_idx_q;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [31:0]      exp_word;
  logic             mismatch;

  rv_chk_rom #(
    .NCHK     (NCHK),
    .IW       (IW),
    .EXP_VALS (EXP_VALS)
  ) u_rom (
    .idx_i  (idx_q),
    .data_o (exp_word)
  );

  assign mismatch     = (rd_data != exp_word);
  assign fail_count_d = fail_count_q + FW'(mismatch);
  assign cycles_d     = (&cycles_q) ? cycles_q : cycles_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_RST;
      cnt_q        <= '0;
      idx_q        <= '0;
      core_rstn_q  <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      timed_out_q  <= 1'b0;
      fail_count_q <= '0;
      ff_idx_q     <= '0;
      ff_data_q    <= '0;
      cycles_q     <= '0;
    end else begin
      case (state_q)
        ST_RST: begin
          if (cnt_q == 32'(RST_CYCLES - 1)) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            core_rstn_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        ST_RUN: begin
          cycles_q <= cycles_d;
          cnt_q    <= cnt_q + 32'd1;
          // A halt seen on the watchdog's last cycle still counts as a halt.
          if (halted) begin
            state_q   <= (DRAIN == 0) ? ST_CHECK : ST_DRAIN;
            rd_en_q   <= (DRAIN == 0);
            cnt_q     <= '0;
            idx_q     <= '0;
            rd_addr_q <= CHK_ADDR0;
          end else if (cnt_q == 32'(TIMEOUT - 1)) begin
            state_q     <= ST_DONE;
            done_q      <= 1'b1;
            timed_out_q <= 1'b1;
            pass_q      <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (cnt_q == 32'(DRAIN - 1)) begin
            state_q <= ST_CHECK;
            rd_en_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        ST_CHECK: begin
          fail_count_q <= fail_count_d;
          if (mismatch && (fail_count_q == '0)) begin
            ff_idx_q  <= idx_q;
            ff_data_q <= rd_data;
          end
          if (idx_q == IW'(NCHK - 1)) begin
            state_q <= ST_DONE;
            rd_en_q <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (fail_count_d == '0);
          end else begin
            idx_q     <= idx_q + IW'(1);
            rd_addr_q <= rd_addr_q + 32'd4;
          end
        end
        ST_DONE: begin
          if (start) begin
            state_q      <= ST_RST;
            cnt_q        <= '0;
            idx_q        <= '0;
            core_rstn_q  <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timed_out_q  <= 1'b0;
            fail_count_q <= '0;
            ff_idx_q     <= '0;
            ff_data_q    <= '0;
            cycles_q     <= '0;
          end
        end
        default: state_q <= ST_RST;
      endcase
    end
  end

  assign core_rstn       = core_rstn_q;
  assign rd_en           = rd_en_q;
  assign rd_addr         = rd_addr_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign timed_out       = timed_out_q;
  assign fail_count      = fail_count_q;
  assign first_fail_idx  = ff_idx_q;
  assign first_fail_data = ff_data_q;
  assign cycles          = cycles_q;

endmodule
